// File: rtl/rb_sequencer.sv
// ---------------------------------------------------------------------------
// rb_sequencer
//
// Frame-level controller for the address generator and the row-buffer BRAM.
// Each batch writes ROWS image rows into the BRAM as bytes, one byte per
// ext_valid beat. It then streams IMG_WIDTH packed column words to the
// consumer, one word per rd_ready beat. FRAME_ROWS/ROWS batches make a frame.
//
// Parameters
//   IMG_WIDTH   pixels per row = column words read per batch
//   ROWS        rows per batch (4, fixed by 32b/8b packing)
//   BRAM_DEPTH  byte locations; equals ROWS*IMG_WIDTH, so it is the number of
//               write beats per batch
//   FRAME_ROWS  image rows per frame; a multiple of ROWS
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   frame start request, sampled in IDLE only
//   ext_valid       in   external memory has a byte this cycle
//   rd_ready        in   consumer accepts a column word this cycle
//   en_e_mem_addr   out  external address advance (combinational, FILL)
//   en_w_bram_addr  out  BRAM write address advance (combinational, FILL)
//   en_r_bram_addr  out  BRAM read address advance (combinational, READ)
//   bram_we         out  en_w_bram_addr delayed 1 cycle (generator latency)
//   rd_valid        out  en_r_bram_addr delayed 2 cycles (generator + BRAM)
//   busy            out  high in any state other than IDLE
//   done            out  one-cycle pulse at end of frame
//   batch_idx       out  index of the current batch
//   stall_cycles    out  [31:0] stall counter, present only with the
//                        RB_STALL_CNT_EN macro defined
//
// Reset does not realign the external address generator, which has no reset.
// After a frame is aborted, the system must be re-initialised.
// ---------------------------------------------------------------------------
module rb_sequencer #(
    parameter int IMG_WIDTH  = 512,
    parameter int ROWS       = 4,
    parameter int BRAM_DEPTH = 2048,
    parameter int FRAME_ROWS = 512
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ext_valid,
    input  logic rd_ready,
    output logic en_e_mem_addr,
    output logic en_w_bram_addr,
    output logic en_r_bram_addr,
    output logic bram_we,
    output logic rd_valid,
    output logic busy,
    output logic done,
    output logic [((FRAME_ROWS/ROWS) > 1 ? $clog2(FRAME_ROWS/ROWS) : 1)-1:0] batch_idx
`ifdef RB_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int BATCHES = FRAME_ROWS / ROWS;
    localparam int BW      = (BATCHES > 1)    ? $clog2(BATCHES)    : 1;
    localparam int FW      = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
    localparam int RW      = (IMG_WIDTH > 1)  ? $clog2(IMG_WIDTH)  : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   fill_cnt;
    logic [RW-1:0]   rd_cnt;
    logic            rd_pipe;      // first stage of the rd_valid delay

    logic            fill_last;
    logic            rd_last;
    logic            batch_last;

    assign fill_last  = (fill_cnt  == FW'(BRAM_DEPTH - 1));
    assign rd_last    = (rd_cnt    == RW'(IMG_WIDTH - 1));
    assign batch_last = (batch_idx == BW'(BATCHES - 1));

    // State register
    // NOTE: clocked blocks use non-blocking (<=) so that every register samples
    // values from before the edge. Blocking (=) is reserved for always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational strobes
    always_comb begin
        // NOTE: every output of this block gets a default first. Any path that
        // left one unassigned would infer a latch.
        state_nxt      = state;
        en_e_mem_addr  = 1'b0;
        en_w_bram_addr = 1'b0;
        en_r_bram_addr = 1'b0;
        busy           = (state != S_IDLE);
        done           = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                en_e_mem_addr  = ext_valid;
                en_w_bram_addr = ext_valid;
                if (ext_valid && fill_last) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                en_r_bram_addr = rd_ready;
                if (rd_ready && rd_last) begin
                    state_nxt = batch_last ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Beat counters and batch index. Every counter holds while its handshake
    // input is low. Each counter wraps to zero on its last beat, so it is
    // already clear when the next batch or frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt  <= '0;
            rd_cnt    <= '0;
            batch_idx <= '0;
        end else begin
            if (state == S_FILL && ext_valid) begin
                fill_cnt <= fill_last ? '0 : fill_cnt + FW'(1);
            end
            if (state == S_READ && rd_ready) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + RW'(1);
                if (rd_last && !batch_last) begin
                    batch_idx <= batch_idx + BW'(1);
                end
            end
            if (state == S_DONE) begin
                batch_idx <= '0;
            end
        end
    end

    // Strobe alignment. The generator updates its address one cycle after an
    // enable. The BRAM adds one more cycle on the read side. The last bram_we
    // of a batch therefore lands in the first READ cycle. That is harmless,
    // because the read starts at column 0, which was written long before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we  <= 1'b0;
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            bram_we  <= en_w_bram_addr;
            rd_pipe  <= en_r_bram_addr;
            rd_valid <= rd_pipe;
        end
    end

`ifdef RB_STALL_CNT_EN
    // Counts cycles in which the active handshake was low. It clears when a
    // frame starts and holds its value after done, so it can be read later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (((state == S_FILL && !ext_valid) ||
                      (state == S_READ && !rd_ready)) &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rb_sequencer
//
// Bench for rb_sequencer with IMG_WIDTH=8, ROWS=4, BRAM_DEPTH=32, FRAME_ROWS=8.
//
// The reference model tracks a frame only as counts of write and read beats.
// The current batch is reads/IMG_WIDTH. A batch is filling until it has taken
// BRAM_DEPTH bytes, and it is reading after that. The frame ends when
// BATCHES*IMG_WIDTH reads have been accepted. The delayed strobes are checked
// against the model's own history of expected enables.
// ---------------------------------------------------------------------------
module tb_rb_sequencer;

    localparam int IMG_WIDTH  = 8;
    localparam int ROWS       = 4;
    localparam int BRAM_DEPTH = 32;
    localparam int FRAME_ROWS = 8;
    localparam int BATCHES    = FRAME_ROWS / ROWS;
    localparam int TOTAL_RD   = BATCHES * IMG_WIDTH;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ext_valid;
    logic       rd_ready;
    logic       en_e_mem_addr;
    logic       en_w_bram_addr;
    logic       en_r_bram_addr;
    logic       bram_we;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic [0:0] batch_idx;
`ifdef RB_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    rb_sequencer #(
        .IMG_WIDTH (IMG_WIDTH),
        .ROWS      (ROWS),
        .BRAM_DEPTH(BRAM_DEPTH),
        .FRAME_ROWS(FRAME_ROWS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ext_valid     (ext_valid),
        .rd_ready      (rd_ready),
        .en_e_mem_addr (en_e_mem_addr),
        .en_w_bram_addr(en_w_bram_addr),
        .en_r_bram_addr(en_r_bram_addr),
        .bram_we       (bram_we),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .done          (done),
        .batch_idx     (batch_idx)
`ifdef RB_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit      m_active;     // frame in progress (FILL or READ)
    bit      m_done;       // this cycle is the done cycle
    int      m_w;          // write beats accepted this frame
    int      m_r;          // read beats accepted this frame
    bit      h_w1;         // expected en_w_bram_addr one cycle ago
    bit      h_r1, h_r2;   // expected en_r_bram_addr one and two cycles ago
    longint  m_stall;

    int cyc = 0;
    int last_done_cyc = -1;
    int done_count = 0;
    int we_pulses = 0;
    int rv_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_filling();
        return m_active && (m_w < (m_r / IMG_WIDTH + 1) * BRAM_DEPTH);
    endfunction

    function automatic bit m_reading();
        return m_active && !m_filling();
    endfunction

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_w = 0; m_r = 0;
        h_w1 = 0; h_r1 = 0; h_r2 = 0; m_stall = 0;
    endfunction

    // One clock cycle. Drive the inputs after the falling edge, compare all
    // outputs 1 time unit later, then advance the model as of the next rising
    // edge.
    task automatic step(input logic ev, input logic rr, input logic st);
        bit fil, rdg, e_w, e_r;
        @(negedge clk);
        ext_valid = ev; rd_ready = rr; start = st;
        #1;
        fil = m_filling();
        rdg = m_reading();
        e_w = fil && ev;
        e_r = rdg && rr;
        check("busy",     32'(busy),           32'(m_active || m_done));
        check("done",     32'(done),           32'(m_done));
        check("en_e",     32'(en_e_mem_addr),  32'(e_w));
        check("en_w",     32'(en_w_bram_addr), 32'(e_w));
        check("en_r",     32'(en_r_bram_addr), 32'(e_r));
        check("bram_we",  32'(bram_we),        32'(h_w1));
        check("rd_valid", 32'(rd_valid),       32'(h_r2));
        if (m_active)
            check("batch_idx", 32'(batch_idx), 32'(m_r / IMG_WIDTH));
        else if (!m_done)
            check("batch_idx_idle", 32'(batch_idx), 32'd0);
`ifdef RB_STALL_CNT_EN
        check("stall_cycles", stall_cycles, 32'(m_stall));
`endif
        if (done === 1'b1) begin
            last_done_cyc = cyc;
            done_count++;
        end
        if (bram_we === 1'b1) we_pulses++;
        if (rd_valid === 1'b1) rv_pulses++;
        cyc++;

        // Model advance
        h_r2 = h_r1; h_r1 = e_r; h_w1 = e_w;
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_w = 0; m_r = 0; m_stall = 0;
            end
        end else begin
            if ((fil && !ev) || (rdg && !rr)) m_stall++;
            if (e_w) m_w++;
            if (e_r) m_r++;
            if (m_r == TOTAL_RD) begin
                m_active = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy),           32'd0);
        check({tag, "_done"},      32'(done),           32'd0);
        check({tag, "_en_e"},      32'(en_e_mem_addr),  32'd0);
        check({tag, "_en_w"},      32'(en_w_bram_addr), 32'd0);
        check({tag, "_en_r"},      32'(en_r_bram_addr), 32'd0);
        check({tag, "_bram_we"},   32'(bram_we),        32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),       32'd0);
        check({tag, "_batch_idx"}, 32'(batch_idx),      32'd0);
`ifdef RB_STALL_CNT_EN
        check({tag, "_stall"},     stall_cycles,        32'd0);
`endif
    endtask

    initial begin
        int c0;
        int n;
        int rd_stalls;
        int ev_stalls;
        bit ev;
        bit rr;

        rst_n = 1'b0; start = 1'b0; ext_valid = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0);

        // 1: free-running frame. done arrives 1+2*(32+8) cycles after the start
        // sample, with 64 write pulses and 16 read-valid pulses.
        we_pulses = 0; rv_pulses = 0; done_count = 0; last_done_cyc = -1;
        c0 = cyc;
        step(1, 1, 1);
        n = 0;
        while (last_done_cyc < 0 && n < 300) begin step(1, 1, 0); n++; end
        check("t1_done_cycle", 32'(last_done_cyc - c0), 32'd81);
        repeat (3) step(1, 1, 0);
        check("t1_we_pulses", 32'(we_pulses), 32'd64);
        check("t1_rv_pulses", 32'(rv_pulses), 32'd16);
        check("t1_done_count", 32'(done_count), 32'd1);

        // 2: ext_valid toggles during FILL, so there are exactly 32 bram_we
        // pulses per batch.
        we_pulses = 0; rv_pulses = 0; last_done_cyc = -1;
        step(1, 1, 1);
        n = 0;
        while (last_done_cyc < 0 && n < 400) begin step(n[0] == 1'b0, 1, 0); n++; end
        repeat (3) step(1, 1, 0);
        check("t2_done_seen", 32'(last_done_cyc >= 0), 32'd1);
        check("t2_we_pulses", 32'(we_pulses), 32'd64);
        check("t2_rv_pulses", 32'(rv_pulses), 32'd16);

        // 3 and 6: rd_ready is low for 5 cycles in the middle of batch 0's read,
        // and ext_valid is low for 3 cycles during the fill.
        we_pulses = 0; rv_pulses = 0; last_done_cyc = -1;
        rd_stalls = 0; ev_stalls = 0;
        step(1, 1, 1);
        n = 0;
        while (last_done_cyc < 0 && n < 400) begin
            ev = !(m_filling() && m_w == 10 && ev_stalls < 3);
            rr = !(m_reading() && m_r == 3 && rd_stalls < 5);
            if (!ev) ev_stalls++;
            if (!rr) rd_stalls++;
            step(ev, rr, 0);
            n++;
        end
`ifdef RB_STALL_CNT_EN
        check("t6_stall_at_done", stall_cycles, 32'd8);
`endif
        repeat (3) step(1, 1, 0);
        check("t3_rv_pulses", 32'(rv_pulses), 32'd16);
        check("t3_we_pulses", 32'(we_pulses), 32'd64);

        // 4: start is held high. The frame runs once, and the next frame starts
        // only from IDLE.
        done_count = 0; last_done_cyc = -1;
        n = 0;
        while (last_done_cyc < 0 && n < 300) begin step(1, 1, 1); n++; end
        check("t4_done_count", 32'(done_count), 32'd1);
        step(1, 1, 1);   // IDLE samples start
        step(1, 1, 1);   // second frame is running

        // 5: asynchronous reset during the read of batch 0
        n = 0;
        while (!(m_reading() && m_r == 3) && n < 100) begin step(1, 1, 0); n++; end
        check("t5_reached_read", 32'(m_reading()), 32'd1);
        @(negedge clk);
        ext_valid = 1'b1; rd_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Randomized handshakes and starts, checked every cycle by the model
        done_count = 0;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0);
        end
        check("rand_frames_seen", 32'(done_count > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
